// File: rtl/sseg_scan_controller_pkg.sv
// rtl/sseg_scan_controller_pkg.sv - scan FSM encodings, blank codes and BCD segment patterns
package sseg_scan_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [6:0] SEG7_OFF   = 7'h7F;

  localparam int unsigned MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Active-low a..g in bits [6:0]
  localparam logic [6:0] SEG7_0 = 7'b0000001;
  localparam logic [6:0] SEG7_1 = 7'b1001111;
  localparam logic [6:0] SEG7_2 = 7'b0010010;
  localparam logic [6:0] SEG7_3 = 7'b0000110;
  localparam logic [6:0] SEG7_4 = 7'b1001100;
  localparam logic [6:0] SEG7_5 = 7'b0100100;
  localparam logic [6:0] SEG7_6 = 7'b0100000;
  localparam logic [6:0] SEG7_7 = 7'b0001111;
  localparam logic [6:0] SEG7_8 = 7'b0000000;
  localparam logic [6:0] SEG7_9 = 7'b0000100;

  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_scan_controller_if.sv
// rtl/sseg_scan_controller_if.sv - digit load inputs and multiplexed display outputs
interface sseg_scan_controller_if #(
  parameter int N_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic [N_DIGITS-1:0]     anode_n;
  logic [7:0]              sseg;
  logic                    frame_done;

  modport master (
    output enable, load, digits_in, dp_in,
    input  anode_n, sseg, frame_done
  );

  modport slave (
    input  enable, load, digits_in, dp_in,
    output anode_n, sseg, frame_done
  );
endinterface

// File: rtl/sseg_digit_decode.sv
// rtl/sseg_digit_decode.sv - combinational BCD + dp to active-low 8-bit segment code
module sseg_digit_decode
  import sseg_scan_controller_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg_n
);

  // Codes A-F come back from bcd_to_seg7 as all-off; dp is independent of blanking
  always_comb begin
    seg_n      = SSEG_BLANK;
    seg_n[7]   = ~dp;
    seg_n[6:0] = blank ? SEG7_OFF : bcd_to_seg7(bcd);
  end

endmodule

// File: rtl/sseg_scan_controller.sv
// rtl/sseg_scan_controller.sv - blanked, tear-free N-digit 7-segment scanner
// Optional LEADING_ZERO_BLANK_EN: blank zero digits above the most-significant nonzero digit.
module sseg_scan_controller
  import sseg_scan_controller_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                   clk,
  input  logic                   reset,
  sseg_scan_controller_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DW-1:0]         active_q, active_d;
  logic [N_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic [N_DIGITS-1:0]   pending_dp_q, pending_dp_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]            sseg_q, sseg_d;
  logic                  frame_done_q, frame_done_d;

  logic                  frame_end;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [3:0]            cur_bcd;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [7:0]            cur_seg;

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin : lz_calc
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      seen        = seen | (active_q[4*i +: 4] != 4'h0);
      lz_blank[i] = ~seen;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Decode the digit that will be on the bus next cycle; active only changes
  // while dark, so reading active_q here never mixes two frames.
  assign cur_bcd   = active_q[4*idx_d +: 4];
  assign cur_dp    = active_dp_q[idx_d];
  assign cur_blank = lz_blank[idx_d];

  sseg_digit_decode u_decode (
    .bcd   (cur_bcd),
    .dp    (cur_dp),
    .blank (cur_blank),
    .seg_n (cur_seg)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    frame_end = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
          end
          cnt_d = cnt_q + CNT_ONE;
        end
        ST_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d     = '0;
              frame_end = 1'b1;
            end else begin
              idx_d = idx_q + IDX_ONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Loads land in active only while idle or at a frame boundary; a load on the
  // boundary edge still queues behind the value being promoted.
  always_comb begin
    active_d        = active_q;
    active_dp_d     = active_dp_q;
    pending_d       = pending_q;
    pending_dp_d    = pending_dp_q;
    pending_valid_d = pending_valid_q;

    if (frame_end && pending_valid_q) begin
      active_d        = pending_q;
      active_dp_d     = pending_dp_q;
      pending_valid_d = 1'b0;
    end

    if (bus.load) begin
      if (state_q == ST_IDLE) begin
        active_d    = bus.digits_in;
        active_dp_d = bus.dp_in;
      end else begin
        pending_d       = bus.digits_in;
        pending_dp_d    = bus.dp_in;
        pending_valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    anode_d      = ANODE_OFF[N_DIGITS-1:0];
    sseg_d       = SSEG_BLANK;
    frame_done_d = 1'b0;
    if (state_d == ST_DRIVE) begin
      anode_d[idx_d] = 1'b0;
      sseg_d         = cur_seg;
      frame_done_d   = (cnt_d == SLOT_LAST) && (idx_d == IDX_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      active_q        <= '0;
      active_dp_q     <= '0;
      pending_q       <= '0;
      pending_dp_q    <= '0;
      pending_valid_q <= 1'b0;
      anode_q         <= ANODE_OFF[N_DIGITS-1:0];
      sseg_q          <= SSEG_BLANK;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      active_q        <= active_d;
      active_dp_q     <= active_dp_d;
      pending_q       <= pending_d;
      pending_dp_q    <= pending_dp_d;
      pending_valid_q <= pending_valid_d;
      anode_q         <= anode_d;
      sseg_q          <= sseg_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign bus.anode_n    = anode_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// tb/tb_sseg_scan_controller.sv - directed vectors plus random stimulus against a frame-position model
module tb_sseg_scan_controller;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
  localparam int FRAME = N * R;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ_EN = 1'b1;
`else
  localparam bit LZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sseg_scan_controller_if #(.N_DIGITS(N)) bus ();

  sseg_scan_controller #(
    .N_DIGITS     (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: position within the frame, plus the shown/queued values
  logic [6:0]  seg_tab [16];
  bit          running;
  int          p;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pv;
  logic [3:0]  exp_anode;
  logic [7:0]  exp_sseg;
  logic        exp_fd;

  typedef struct {
    bit          en;
    bit          ld;
    logic [15:0] digits;
    logic [3:0]  dp;
    int          ncyc;
    logic [3:0]  anode;
    logic [7:0]  sseg;
    logic        fd;
  } vec_t;
  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit was_run;
    bit fe;
    bit blank;
    int d;
    if (reset) begin
      running = 0; p = 0;
      m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 0;
    end else begin
      was_run = running;
      fe = 0;
      if (!bus.enable) begin
        running = 0; p = 0;
      end else if (!running) begin
        running = 1; p = 0;
      end else begin
        fe = (p == FRAME - 1);
        p = (p + 1) % FRAME;
      end
      if (fe && m_pv) begin
        m_act = m_pend; m_act_dp = m_pend_dp; m_pv = 0;
      end
      if (bus.load) begin
        if (!was_run) begin
          m_act = bus.digits_in; m_act_dp = bus.dp_in;
        end else begin
          m_pend = bus.digits_in; m_pend_dp = bus.dp_in; m_pv = 1;
        end
      end
    end
    exp_anode = 4'hF;
    exp_sseg  = 8'hFF;
    exp_fd    = 1'b0;
    if (running && (p % R) >= B) begin
      d = p / R;
      exp_anode = 4'hF & ~(4'(1) << d);
      blank = LZ_EN && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
      exp_sseg = {~m_act_dp[d], blank ? 7'h7F : seg_tab[m_act[4*d +: 4]]};
      exp_fd = (p == FRAME - 1);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    check("model", {19'h0, bus.anode_n, bus.sseg, bus.frame_done},
          {19'h0, exp_anode, exp_sseg, exp_fd});
  endtask

  task automatic check_out(input string name, input logic [3:0] an, input logic [7:0] sg, input logic fd);
    check({name, ".anode_n"}, {28'h0, bus.anode_n}, {28'h0, an});
    check({name, ".sseg"}, {24'h0, bus.sseg}, {24'h0, sg});
    check({name, ".frame_done"}, {31'h0, bus.frame_done}, {31'h0, fd});
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus.load = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    reset = 1'b0;
  endtask

  task automatic pulse_load(input logic [15:0] dg, input logic [3:0] dpv);
    bus.load = 1'b1; bus.digits_in = dg; bus.dp_in = dpv;
    cycle();
    bus.load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
    seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0000100;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'h7F;

    //          en  ld  digits    dp     n   anode    sseg   fd
    vecs[0]  = '{1, 1, 16'h1234, 4'h0,  1, 4'b1111, 8'hFF, 0};
    vecs[1]  = '{1, 0, 16'h0000, 4'h0,  2, 4'b1110, 8'hCC, 0};
    vecs[2]  = '{1, 0, 16'h0000, 4'h0,  5, 4'b1110, 8'hCC, 0};
    vecs[3]  = '{1, 0, 16'h0000, 4'h0,  1, 4'b1111, 8'hFF, 0};
    vecs[4]  = '{1, 0, 16'h0000, 4'h0,  2, 4'b1101, 8'h86, 0};
    vecs[5]  = '{1, 1, 16'h5678, 4'h0,  8, 4'b1011, 8'h92, 0};
    vecs[6]  = '{1, 0, 16'h0000, 4'h0, 13, 4'b0111, 8'hCF, 1};
    vecs[7]  = '{1, 0, 16'h0000, 4'h0,  3, 4'b1110, 8'h80, 0};
    vecs[8]  = '{1, 0, 16'h0000, 4'h0, 17, 4'b1011, 8'hA0, 0};
    vecs[9]  = '{0, 0, 16'h0000, 4'h0,  1, 4'b1111, 8'hFF, 0};
    vecs[10] = '{0, 0, 16'h0000, 4'h0,  3, 4'b1111, 8'hFF, 0};
    vecs[11] = '{1, 1, 16'h56A8, 4'h2,  2, 4'b1111, 8'hFF, 0};
    vecs[12] = '{1, 0, 16'h0000, 4'h0,  1, 4'b1110, 8'h80, 0};
    vecs[13] = '{1, 0, 16'h0000, 4'h0,  8, 4'b1101, 8'h7F, 0};

    reset = 1'b1;
    bus.enable = 1'b1; bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0;
    running = 0; p = 0; m_act = '0; m_act_dp = '0; m_pend = '0; m_pend_dp = '0; m_pv = 0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) cycle();
    check_out("reset", 4'b1111, 8'hFF, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      bus.enable = vecs[i].en;
      if (vecs[i].ld) begin
        bus.load = 1'b1; bus.digits_in = vecs[i].digits; bus.dp_in = vecs[i].dp;
      end
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        cycle();
        bus.load = 1'b0;
      end
      check_out($sformatf("vec%0d", i), vecs[i].anode, vecs[i].sseg, vecs[i].fd);
    end

    // Double load mid-frame, then a load on the frame-end edge itself
    bus.enable = 1'b1;
    do_reset(2);
    pulse_load(16'h1111, 4'h0);
    for (int e = 2; e <= 32; e++) begin
      if (e == 10) pulse_load(16'h2222, 4'h0);
      else if (e == 20) pulse_load(16'h3333, 4'h0);
      else cycle();
    end
    pulse_load(16'h4444, 4'h0);
    for (int e = 34; e <= 35; e++) cycle();
    check_out("latest_wins", 4'b1110, 8'h86, 1'b0);
    for (int e = 36; e <= 64; e++) cycle();
    check_out("frame2_end", 4'b0111, 8'h86, 1'b1);
    for (int e = 65; e <= 67; e++) cycle();
    check_out("edge_load", 4'b1110, 8'hCC, 1'b0);

`ifdef LEADING_ZERO_BLANK_EN
    do_reset(2);
    pulse_load(16'h0070, 4'h0);
    for (int e = 2; e <= 3; e++) cycle();
    check_out("lz_d0", 4'b1110, 8'h81, 1'b0);
    for (int e = 4; e <= 11; e++) cycle();
    check_out("lz_d1", 4'b1101, 8'h8F, 1'b0);
    for (int e = 12; e <= 19; e++) cycle();
    check_out("lz_d2", 4'b1011, 8'hFF, 1'b0);
    for (int e = 20; e <= 27; e++) cycle();
    check_out("lz_d3", 4'b0111, 8'hFF, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.enable    = ($urandom_range(0, 999) < 996);
      bus.load      = ($urandom_range(0, 19) == 0);
      bus.digits_in = 16'($urandom);
      bus.dp_in     = 4'($urandom);
      cycle();
    end
    bus.load = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
